// File: rtl/demod_ctrl_pkg.sv
// Shared types and helpers for the demodulator tuning/squelch scheduler.
// DEMOD_SQ_HYST_EN enables a lower squelch close level (hysteresis).
package demod_ctrl_pkg;

    localparam int POW_WIDTH = 24;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TUNE    = 3'd1,
        SETTLE  = 3'd2,
        MEASURE = 3'd3,
        DECIDE  = 3'd4
    } state_t;

    // Power below this level drops the lock and (when scanning) advances the channel.
    function automatic logic [POW_WIDTH-1:0] close_level(input logic [POW_WIDTH-1:0] thresh);
`ifdef DEMOD_SQ_HYST_EN
        close_level = thresh - (thresh >> 2);
`else
        close_level = thresh;
`endif
    endfunction

endpackage

// File: rtl/demod_tune_ctrl_if.sv
// Demodulated IQ sample stream: valid strobe plus signed I/Q.
interface demod_tune_ctrl_if #(
    parameter int IQ_WIDTH = 12
);
    logic                       iq_valid;
    logic signed [IQ_WIDTH-1:0] I_in;
    logic signed [IQ_WIDTH-1:0] Q_in;

    modport master (output iq_valid, I_in, Q_in);
    modport slave  (input  iq_valid, I_in, Q_in);
endinterface

// File: rtl/demod_tune_ctrl_acc.sv
// Window power accumulator: sums I^2+Q^2 over 2^MEAS_LOG2 strobes and
// reports the truncated mean; clear has priority over accumulate.
module iq_power_acc
    import demod_ctrl_pkg::*;
#(
    parameter int IQ_WIDTH  = 12,
    parameter int MEAS_LOG2 = 8
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [IQ_WIDTH-1:0] i_smp,
    input  logic signed [IQ_WIDTH-1:0] q_smp,
    output logic                       done,
    output logic [POW_WIDTH-1:0]       power
);

    localparam int ACC_W = POW_WIDTH + MEAS_LOG2;

    logic signed [IQ_WIDTH-1:0]   smp [2];
    logic [POW_WIDTH-1:0]         sq  [2];
    logic [POW_WIDTH-1:0]         sum;
    logic [ACC_W-1:0]             acc_reg;
    logic [MEAS_LOG2-1:0]         cnt_reg;

    assign smp[0] = i_smp;
    assign smp[1] = q_smp;

    // The full signed product is never negative and at most 2^(2*IQ_WIDTH-2),
    // so its bit pattern is the unsigned square directly.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_square
            logic signed [2*IQ_WIDTH-1:0] prod;
            assign prod   = smp[gi] * smp[gi];
            assign sq[gi] = POW_WIDTH'($unsigned(prod));
        end
    endgenerate

    assign sum   = sq[0] + sq[1];
    assign done  = en && (&cnt_reg);
    assign power = acc_reg[ACC_W-1:MEAS_LOG2];

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + ACC_W'(sum);
            cnt_reg <= cnt_reg + MEAS_LOG2'(1);
        end
    end

endmodule

// File: rtl/demod_tune_ctrl.sv
// Tuning and squelch scheduler: drives the LO word and demod reset, measures
// window power, locks or scans channels. Build option: DEMOD_SQ_HYST_EN.
module demod_tune_ctrl
    import demod_ctrl_pkg::*;
#(
    parameter int                    IQ_WIDTH      = 12,
    parameter int                    FREQ_WIDTH    = 32,
    parameter int                    CH_BITS       = 4,
    parameter logic [FREQ_WIDTH-1:0] BASE_FREQ     = 32'd459561501,
    parameter logic [FREQ_WIDTH-1:0] STEP_FREQ     = 32'd10737418,
    parameter int                    SETTLE_CYCLES = 256,
    parameter int                    MEAS_LOG2     = 8
) (
    input  logic                  clk_in,
    input  logic                  RST,
    input  logic                  tune_req,
    input  logic [CH_BITS-1:0]    tune_ch,
    input  logic                  scan_en,
    input  logic [POW_WIDTH-1:0]  sq_thresh,
    demod_tune_ctrl_if.slave      iq,
    output logic [FREQ_WIDTH-1:0] LO_fre,
    output logic                  demod_rst,
    output logic                  audio_mute,
    output logic [CH_BITS-1:0]    cur_ch,
    output logic                  locked,
    output logic                  busy,
    output logic [POW_WIDTH-1:0]  power_out
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_t                state_reg, state_next;
    logic [CH_BITS-1:0]    cur_ch_reg, cur_ch_next;
    logic [FREQ_WIDTH-1:0] lo_fre_reg, lo_fre_next;
    logic                  locked_reg, locked_next;
    logic [POW_WIDTH-1:0]  power_reg, power_next;
    logic [CNT_W-1:0]      settle_cnt_reg, settle_cnt_next;

    logic                  acc_clr;
    logic                  acc_en;
    logic                  acc_done;
    logic [POW_WIDTH-1:0]  acc_power;

    iq_power_acc #(
        .IQ_WIDTH  (IQ_WIDTH),
        .MEAS_LOG2 (MEAS_LOG2)
    ) u_acc (
        .clk   (clk_in),
        .srst  (RST),
        .clr   (acc_clr),
        .en    (acc_en),
        .i_smp (iq.I_in),
        .q_smp (iq.Q_in),
        .done  (acc_done),
        .power (acc_power)
    );

    always_ff @(posedge clk_in) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            cur_ch_reg     <= '0;
            lo_fre_reg     <= BASE_FREQ;
            locked_reg     <= 1'b0;
            power_reg      <= '0;
            settle_cnt_reg <= '0;
        end else begin
            cur_ch_reg     <= cur_ch_next;
            lo_fre_reg     <= lo_fre_next;
            locked_reg     <= locked_next;
            power_reg      <= power_next;
            settle_cnt_reg <= settle_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cur_ch_next     = cur_ch_reg;
        lo_fre_next     = lo_fre_reg;
        locked_next     = locked_reg;
        power_next      = power_reg;
        settle_cnt_next = settle_cnt_reg;
        acc_clr         = 1'b0;
        acc_en          = 1'b0;

        unique case (state_reg)
            IDLE: begin
            end
            TUNE: begin
                settle_cnt_next = '0;
                acc_clr         = 1'b1;
                state_next      = SETTLE;
            end
            SETTLE: begin
                if (iq.iq_valid) begin
                    if (settle_cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
                        settle_cnt_next = '0;
                        state_next      = MEASURE;
                    end else begin
                        settle_cnt_next = settle_cnt_reg + CNT_W'(1);
                    end
                end
            end
            MEASURE: begin
                acc_en = iq.iq_valid;
                if (acc_done) begin
                    state_next = DECIDE;
                end
            end
            DECIDE: begin
                power_next = acc_power;
                acc_clr    = 1'b1;
                state_next = MEASURE;
                if (acc_power >= sq_thresh) begin
                    locked_next = 1'b1;
                end else if (acc_power < close_level(sq_thresh)) begin
                    locked_next = 1'b0;
                    if (scan_en) begin
                        cur_ch_next = cur_ch_reg + CH_BITS'(1);
                        state_next  = TUNE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A manual request overrides whatever the current state decided.
        if (tune_req) begin
            cur_ch_next = tune_ch;
            locked_next = 1'b0;
            state_next  = TUNE;
        end

        if (state_next == TUNE) begin
            lo_fre_next = BASE_FREQ + FREQ_WIDTH'(cur_ch_next) * STEP_FREQ;
        end
    end

    assign LO_fre     = lo_fre_reg;
    assign cur_ch     = cur_ch_reg;
    assign locked     = locked_reg;
    assign audio_mute = ~locked_reg;
    assign power_out  = power_reg;
    assign demod_rst  = (state_reg == IDLE) || (state_reg == TUNE);
    assign busy       = (state_reg == TUNE) || (state_reg == SETTLE) ||
                        (((state_reg == MEASURE) || (state_reg == DECIDE)) && !locked_reg);

endmodule

// File: tb/tb_demod_tune_ctrl.sv
// Self-checking bench for demod_tune_ctrl with random strobe gaps and samples
// against a window-level squelch/scan model.
`timescale 1ns/1ps
module tb_demod_tune_ctrl;
    import demod_ctrl_pkg::*;

    localparam int          SETTLE = 256;
    localparam int          WIN    = 256;
    localparam logic [31:0] BASE   = 32'd459561501;
    localparam logic [31:0] STEP   = 32'd10737418;
`ifdef DEMOD_SQ_HYST_EN
    localparam bit          HYST   = 1'b1;
`else
    localparam bit          HYST   = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        RST = 1'b0;
    logic        tune_req = 1'b0;
    logic [3:0]  tune_ch = '0;
    logic        scan_en = 1'b0;
    logic [23:0] sq_thresh = '0;
    logic [31:0] LO_fre;
    logic        demod_rst, audio_mute, locked, busy;
    logic [3:0]  cur_ch;
    logic [23:0] power_out;

    demod_tune_ctrl_if #(.IQ_WIDTH(12)) iq ();

    demod_tune_ctrl dut (
        .clk_in    (clk_in),
        .RST       (RST),
        .tune_req  (tune_req),
        .tune_ch   (tune_ch),
        .scan_en   (scan_en),
        .sq_thresh (sq_thresh),
        .iq        (iq),
        .LO_fre    (LO_fre),
        .demod_rst (demod_rst),
        .audio_mute(audio_mute),
        .cur_ch    (cur_ch),
        .locked    (locked),
        .busy      (busy),
        .power_out (power_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  m_ch;
    logic        m_locked;
    logic [23:0] m_power;

    function automatic logic [31:0] exp_lo(input logic [3:0] ch);
        longint r;
        r = longint'(BASE) + longint'(ch) * longint'(STEP);
        return r[31:0];
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_random_iq(input bit v);
        int ii, qq;
        ii = int'($urandom_range(4095)) - 2048;
        qq = int'($urandom_range(4095)) - 2048;
        iq.iq_valid = v;
        iq.I_in     = ii[11:0];
        iq.Q_in     = qq[11:0];
    endtask

    task automatic test_reset();
        RST = 1'b1; tune_req = 1'b0; scan_en = 1'b0; iq.iq_valid = 1'b0;
        iq.I_in = '0; iq.Q_in = '0;
        repeat (3) step();
        RST = 1'b0;
        m_ch = '0; m_locked = 1'b0; m_power = '0;
        n_checks++; if (LO_fre !== BASE) begin n_fail++; $display("FAIL reset_lo: got %0d want %0d", LO_fre, BASE); end
        n_checks++; if (cur_ch !== 4'd0) begin n_fail++; $display("FAIL reset_ch: got %0d want 0", cur_ch); end
        n_checks++; if (demod_rst !== 1'b1) begin n_fail++; $display("FAIL reset_demod_rst: got %b want 1", demod_rst); end
        n_checks++; if (audio_mute !== 1'b1) begin n_fail++; $display("FAIL reset_mute: got %b want 1", audio_mute); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (power_out !== 24'd0) begin n_fail++; $display("FAIL reset_power: got %0d want 0", power_out); end
        step();
        n_checks++; if (demod_rst !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got rst=%b busy=%b want rst=1 busy=0", demod_rst, busy); end
        $display("reset done: LO=%0d ch=%0d", LO_fre, cur_ch);
    endtask

    // Issue tune_req for one cycle; returns in the TUNE cycle.
    task automatic start_tune(input logic [3:0] ch);
        tune_req = 1'b1; tune_ch = ch;
        drive_random_iq($urandom_range(1));
        step();
        tune_req = 1'b0;
        m_ch = ch; m_locked = 1'b0;
        n_checks++; if (cur_ch !== m_ch) begin n_fail++; $display("FAIL tune_ch: got %0d want %0d", cur_ch, m_ch); end
        n_checks++; if (LO_fre !== exp_lo(m_ch)) begin n_fail++; $display("FAIL tune_lo: got %0d want %0d", LO_fre, exp_lo(m_ch)); end
        n_checks++; if (demod_rst !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL tune_flags: got rst=%b busy=%b want 1 1", demod_rst, busy); end
        n_checks++; if (locked !== 1'b0 || audio_mute !== 1'b1) begin n_fail++; $display("FAIL tune_unlock: got locked=%b mute=%b want 0 1", locked, audio_mute); end
        n_checks++; if (power_out !== m_power) begin n_fail++; $display("FAIL tune_power_hold: got %0d want %0d", power_out, m_power); end
        $display("tune ch=%0d LO=%0d", cur_ch, LO_fre);
    endtask

    // From the TUNE cycle through SETTLE; returns in the first MEASURE cycle.
    task automatic do_settle();
        int got = 0;
        bit v;
        drive_random_iq(1'b1);
        step();
        while (got < SETTLE) begin
            v = ($urandom_range(3) != 0);
            drive_random_iq(v);
            step();
            if (v) got++;
        end
        n_checks++; if (demod_rst !== 1'b0 || power_out !== m_power) begin n_fail++; $display("FAIL settle_end: got rst=%b power=%0d want 0 %0d", demod_rst, power_out, m_power); end
        $display("settle done ch=%0d", cur_ch);
    endtask

    // One measurement window plus its decision; rnd selects random samples.
    task automatic do_window(input int fi, input int fq, input bit rnd,
                             input bit req, input logic [3:0] rch);
        longint sum = 0;
        int     got = 0;
        int     ii, qq;
        bit     v, tune_next;
        logic [23:0] p, close_lv;
        while (got < WIN) begin
            v  = ($urandom_range(3) != 0);
            ii = rnd ? int'($urandom_range(4095)) - 2048 : fi;
            qq = rnd ? int'($urandom_range(4095)) - 2048 : fq;
            iq.iq_valid = v; iq.I_in = ii[11:0]; iq.Q_in = qq[11:0];
            step();
            if (v) begin
                sum += longint'(ii * ii + qq * qq);
                got++;
            end
        end
        n_checks++; if (locked !== m_locked || power_out !== m_power) begin n_fail++; $display("FAIL decide_early: got locked=%b power=%0d want %b %0d", locked, power_out, m_locked, m_power); end
        n_checks++; if (demod_rst !== 1'b0) begin n_fail++; $display("FAIL decide_rst: got %b want 0", demod_rst); end
        iq.iq_valid = 1'b1; iq.I_in = 12'h800; iq.Q_in = 12'h800;
        tune_req = req; tune_ch = rch;
        step();
        tune_req = 1'b0; iq.iq_valid = 1'b0;
        p        = 24'(sum / WIN);
        close_lv = HYST ? sq_thresh - (sq_thresh >> 2) : sq_thresh;
        m_power  = p;
        tune_next = 1'b0;
        if (p >= sq_thresh) m_locked = 1'b1;
        else if (p < close_lv) begin
            m_locked = 1'b0;
            if (scan_en) begin m_ch = m_ch + 4'd1; tune_next = 1'b1; end
        end
        if (req) begin m_ch = rch; m_locked = 1'b0; tune_next = 1'b1; end
        n_checks++; if (power_out !== m_power) begin n_fail++; $display("FAIL win_power: got %0d want %0d", power_out, m_power); end
        n_checks++; if (locked !== m_locked || audio_mute !== ~m_locked) begin n_fail++; $display("FAIL win_locked: got locked=%b mute=%b want %b %b", locked, audio_mute, m_locked, ~m_locked); end
        n_checks++; if (cur_ch !== m_ch) begin n_fail++; $display("FAIL win_ch: got %0d want %0d", cur_ch, m_ch); end
        n_checks++; if (demod_rst !== tune_next || busy !== (tune_next || !m_locked)) begin n_fail++; $display("FAIL win_next: got rst=%b busy=%b want %b %b", demod_rst, busy, tune_next, tune_next || !m_locked); end
        if (tune_next) begin
            n_checks++; if (LO_fre !== exp_lo(m_ch)) begin n_fail++; $display("FAIL win_lo: got %0d want %0d", LO_fre, exp_lo(m_ch)); end
        end
        $display("window ch=%0d thresh=%0d power=%0d locked=%b", cur_ch, sq_thresh, power_out, locked);
    endtask

    task automatic test_manual_tune();
        scan_en = 1'b0; sq_thresh = 24'd10000;
        start_tune(4'd3);
        n_checks++; if (LO_fre !== 32'd491773755) begin n_fail++; $display("FAIL manual_lo: got %0d want 491773755", LO_fre); end
        do_settle();
        do_window(100, 100, 1'b0, 1'b0, 4'd0);
        n_checks++; if (power_out !== 24'd20000 || locked !== 1'b1 || audio_mute !== 1'b0) begin n_fail++; $display("FAIL manual_lock: got power=%0d locked=%b mute=%b want 20000 1 0", power_out, locked, audio_mute); end
        do_window(0, 0, 1'b1, 1'b0, 4'd0);
    endtask

    task automatic test_random_thresh();
        scan_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sq_thresh = 24'($urandom_range(3000000, 2500000));
            do_window(0, 0, 1'b1, 1'b0, 4'd0);
        end
    endtask

    task automatic test_hysteresis();
        scan_en = 1'b0; sq_thresh = 24'd10000;
        do_window(100, 100, 1'b0, 1'b0, 4'd0);
        do_window(63, 63, 1'b0, 1'b0, 4'd0);
        n_checks++; if (power_out !== 24'd7938 || locked !== HYST) begin n_fail++; $display("FAIL hyst: got power=%0d locked=%b want 7938 %b", power_out, locked, HYST); end
    endtask

    task automatic test_full_scale();
        scan_en = 1'b0; sq_thresh = 24'd10000;
        do_window(-2048, -2048, 1'b0, 1'b0, 4'd0);
        n_checks++; if (power_out !== 24'd8388608) begin n_fail++; $display("FAIL full_scale: got %0d want 8388608", power_out); end
    endtask

    task automatic test_scan_wrap();
        scan_en = 1'b1; sq_thresh = 24'd10000;
        start_tune(4'd14);
        do_settle();
        do_window(0, 0, 1'b0, 1'b0, 4'd0);
        do_settle();
        do_window(0, 0, 1'b0, 1'b0, 4'd0);
        n_checks++; if (cur_ch !== 4'd0 || demod_rst !== 1'b1) begin n_fail++; $display("FAIL scan_wrap: got ch=%0d rst=%b want 0 1", cur_ch, demod_rst); end
        do_settle();
        do_window(100, 100, 1'b0, 1'b0, 4'd0);
        n_checks++; if (cur_ch !== 4'd0 || locked !== 1'b1) begin n_fail++; $display("FAIL scan_lock: got ch=%0d locked=%b want 0 1", cur_ch, locked); end
    endtask

    task automatic test_back_to_back();
        scan_en = 1'b1; sq_thresh = 24'd10000;
        do_window(0, 0, 1'b0, 1'b1, 4'd9);
        n_checks++; if (cur_ch !== 4'd9) begin n_fail++; $display("FAIL req_wins: got ch=%0d want 9", cur_ch); end
        do_settle();
        scan_en = 1'b0;
        do_window(0, 0, 1'b0, 1'b0, 4'd0);
        n_checks++; if (cur_ch !== 4'd9 || demod_rst !== 1'b0) begin n_fail++; $display("FAIL scan_stop: got ch=%0d rst=%b want 9 0", cur_ch, demod_rst); end
    endtask

    task automatic test_abort();
        scan_en = 1'b0; sq_thresh = 24'd10000;
        start_tune(4'd5);
        do_settle();
        do_window(100, 100, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 100; k++) begin
            drive_random_iq($urandom_range(1));
            step();
        end
        start_tune(4'd7);
        n_checks++; if (power_out !== 24'd20000) begin n_fail++; $display("FAIL abort_power_hold: got %0d want 20000", power_out); end
        do_settle();
        do_window(50, 50, 1'b0, 1'b0, 4'd0);
        n_checks++; if (power_out !== 24'd5000 || cur_ch !== 4'd7) begin n_fail++; $display("FAIL abort_window: got power=%0d ch=%0d want 5000 7", power_out, cur_ch); end
    endtask

    task automatic test_rst_priority();
        RST = 1'b1; tune_req = 1'b1; tune_ch = 4'd11;
        step();
        RST = 1'b0; tune_req = 1'b0;
        m_ch = '0; m_locked = 1'b0; m_power = '0;
        n_checks++; if (cur_ch !== 4'd0 || LO_fre !== BASE) begin n_fail++; $display("FAIL rst_prio_ch: got ch=%0d LO=%0d want 0 %0d", cur_ch, LO_fre, BASE); end
        n_checks++; if (demod_rst !== 1'b1 || busy !== 1'b0 || power_out !== 24'd0 || locked !== 1'b0) begin n_fail++; $display("FAIL rst_prio_flags: got rst=%b busy=%b power=%0d locked=%b want 1 0 0 0", demod_rst, busy, power_out, locked); end
        $display("mid-run reset ch=%0d", cur_ch);
    endtask

    initial begin
        test_reset();
        test_manual_tune();
        test_random_thresh();
        test_hysteresis();
        test_full_scale();
        test_scan_wrap();
        test_back_to_back();
        test_abort();
        test_rst_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
